mult_issue_ctrl: RTL

MULT_ISSUE_CTRL -- requirements
Module: mult_issue_ctrl

---
 rtl/mult_pkg.sv | 24 ++
 rtl/mult_opnd_fifo.sv | 62 ++++++
 rtl/mult_issue_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared defaults and FSM encoding for the multiplier issue controller.
// Imported by the controller and its operand buffer.
package mult_pkg;

   localparam int MULT_W_DEF     = 8;
   localparam int MULT_DEPTH_DEF = 4;
   localparam int MULT_LAT_DEF   = 9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } mult_state_e;

   // Advance a circular-buffer pointer, wrapping at the last entry.
   function automatic int unsigned ptr_next(
      input int unsigned ptr,
      input int unsigned depth
   );
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/mult_opnd_fifo.sv
// Synchronous operand-pair buffer feeding the multiplier issue FSM.
// Registered count drives full/empty so in_ready never bypasses.
module mult_opnd_fifo
   import mult_pkg::*;
#(
   parameter int DW    = 16,
   parameter int DEPTH = MULT_DEPTH_DEF,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rptr];

   // Storage array; contents need no reset, the count qualifies them.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr] <= din;
      end
   end

   // Pointers and occupancy; simultaneous push and pop keep the count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            wptr <= AW'(ptr_next(32'(wptr), DEPTH));
         end
         if (do_pop) begin
            rptr <= AW'(ptr_next(32'(rptr), DEPTH));
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issues buffered operand pairs to a fixed-latency booth multiplier,
// one at a time, and holds each product until downstream accepts it.
module mult_issue_ctrl
   import mult_pkg::*;
#(
   parameter int W          = MULT_W_DEF,
   parameter int FIFO_DEPTH = MULT_DEPTH_DEF,
   parameter int MULT_LAT   = MULT_LAT_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_a,
   input  logic [W-1:0]   in_b,
   output logic [W-1:0]   mult_a,
   output logic [W-1:0]   mult_b,
   output logic           mult_load,
   input  logic [2*W-1:0] mult_y,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] out_y,
   output logic           busy
);

   localparam int CNT_W = $clog2(MULT_LAT + 1);
   localparam int FC_W  = $clog2(FIFO_DEPTH + 1);

   mult_state_e    state;
   mult_state_e    state_nxt;
   logic [CNT_W-1:0] cnt;
   logic           push;
   logic           pop;
   logic           done;
   logic           release_y;
   logic [2*W-1:0] fifo_dout;
   logic           fifo_full;
   logic           fifo_empty;
   logic [FC_W-1:0] fifo_count;

   assign in_ready  = !fifo_full;
   assign push      = in_valid && in_ready;
   assign mult_load = (state == LOAD);
   assign done      = (state == WAIT) && (cnt == '0);
   assign release_y = (state == HOLD) && out_ready;
   assign busy      = (state != IDLE) || (fifo_count != '0);

   mult_opnd_fifo #(
      .DW    (2 * W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   ({in_a, in_b}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Next state and buffer pop; a pop always coincides with entering LOAD.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      unique case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            state_nxt = WAIT;
         end
         WAIT: begin
            if (cnt == '0) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  state_nxt = LOAD;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Latency counter: armed in LOAD, counts down through WAIT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (state == LOAD) begin
         cnt <= CNT_W'(MULT_LAT - 1);
      end else if ((state == WAIT) && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   // Operand registers change only on a pop, so they stay put until HOLD exits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mult_a <= '0;
         mult_b <= '0;
      end else if (pop) begin
         mult_a <= fifo_dout[2*W-1:W];
         mult_b <= fifo_dout[W-1:0];
      end
   end

   // Result capture and downstream valid, held until accepted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_y     <= '0;
         out_valid <= 1'b0;
      end else if (done) begin
         out_y     <= mult_y;
         out_valid <= 1'b1;
      end else if (release_y) begin
         out_valid <= 1'b0;
      end
   end

endmodule
